// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB.
// Starts on the EX_kick_up pulse and runs one request/ready transaction on the
// data bus for loads and stores. Load data is aligned and extended before it
// reaches WB. Illegal accesses and bus timeouts finish early with mem_fault set.
// Everything else passes through with one cycle of latency.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_kick_up,
  input  logic [31:0] ALU_result,
  input  logic [31:0] rs2_data,
  input  logic        Controller_memread,
  input  logic        Controller_memwrite,
  input  logic [2:0]  funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_read_data,
  output logic        MEM_kick_up,
  output logic        mem_fault
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state_q;
  logic [1:0]  offset_q;
  logic [2:0]  funct3_q;
  logic [31:0] timeoutCount_q;
  logic        dmemReq_q;
  logic        dmemWe_q;
  logic [31:0] dmemAddr_q;
  logic [31:0] dmemWdata_q;
  logic [3:0]  dmemBe_q;
  logic [31:0] memReadData_q;
  logic        memKickUp_q;
  logic        memFault_q;

  logic [3:0]  storeBe_d;
  logic [31:0] storeWdata_d;
  logic        accessFault_d;
  logic [31:0] laneShifted;
  logic [31:0] loadData_d;
  logic        timeoutHit;

  // Decode the incoming access: byte lanes for stores, and whether it is illegal.
  always_comb begin
    storeBe_d     = 4'b1111;
    storeWdata_d  = rs2_data;
    accessFault_d = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        storeBe_d    = 4'b0001 << ALU_result[1:0];
        storeWdata_d = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        storeBe_d    = 4'b0011 << ALU_result[1:0];
        storeWdata_d = {2{rs2_data[15:0]}};
      end
      default: begin
        storeBe_d    = 4'b1111;
        storeWdata_d = rs2_data;
      end
    endcase
    if (Controller_memread && Controller_memwrite) begin
      accessFault_d = 1'b1;
    end else if (Controller_memread) begin
      case (funct3)
        3'b000, 3'b100: accessFault_d = 1'b0;
        3'b001, 3'b101: accessFault_d = ALU_result[0];
        3'b010:         accessFault_d = |ALU_result[1:0];
        default:        accessFault_d = 1'b1;
      endcase
    end else if (Controller_memwrite) begin
      case (funct3)
        3'b000:  accessFault_d = 1'b0;
        3'b001:  accessFault_d = ALU_result[0];
        3'b010:  accessFault_d = |ALU_result[1:0];
        default: accessFault_d = 1'b1;
      endcase
    end
  end

  // Shift the addressed lane of the raw bus word down to bit 0, then extend it.
  always_comb begin
    laneShifted = dmem_rdata >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  loadData_d = {{24{laneShifted[7]}}, laneShifted[7:0]};
      3'b001:  loadData_d = {{16{laneShifted[15]}}, laneShifted[15:0]};
      3'b100:  loadData_d = {24'h000000, laneShifted[7:0]};
      3'b101:  loadData_d = {16'h0000, laneShifted[15:0]};
      default: loadData_d = laneShifted;
    endcase
    timeoutHit = (TIMEOUT_CYCLES != 0) && ((timeoutCount_q + 32'd1) == TIMEOUT_CYCLES);
  end

  // Stage FSM. All bus and WB-facing outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      offset_q       <= 2'b00;
      funct3_q       <= 3'b000;
      timeoutCount_q <= '0;
      dmemReq_q      <= 1'b0;
      dmemWe_q       <= 1'b0;
      dmemAddr_q     <= '0;
      dmemWdata_q    <= '0;
      dmemBe_q       <= 4'b0000;
      memReadData_q  <= '0;
      memKickUp_q    <= 1'b0;
      memFault_q     <= 1'b0;
    end else begin
      memKickUp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (EX_kick_up) begin
            offset_q       <= ALU_result[1:0];
            funct3_q       <= funct3;
            timeoutCount_q <= '0;
            memFault_q     <= 1'b0;
            if (accessFault_d) begin
              memFault_q  <= 1'b1;
              memKickUp_q <= 1'b1;
              state_q     <= DONE;
            end else if (!Controller_memread && !Controller_memwrite) begin
              memKickUp_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              dmemReq_q   <= 1'b1;
              dmemWe_q    <= Controller_memwrite;
              dmemAddr_q  <= {ALU_result[31:2], 2'b00};
              dmemBe_q    <= Controller_memwrite ? storeBe_d : 4'b1111;
              dmemWdata_q <= Controller_memwrite ? storeWdata_d : 32'h0;
              state_q     <= BUS;
            end
          end
        end
        BUS: begin
          if (dmem_ready) begin
            dmemReq_q   <= 1'b0;
            dmemWe_q    <= 1'b0;
            memKickUp_q <= 1'b1;
            if (!dmemWe_q) begin
              memReadData_q <= loadData_d;
            end
            state_q <= DONE;
          end else if (timeoutHit) begin
            dmemReq_q     <= 1'b0;
            dmemWe_q      <= 1'b0;
            memFault_q    <= 1'b1;
            memReadData_q <= '0;
            memKickUp_q   <= 1'b1;
            state_q       <= DONE;
          end else begin
            timeoutCount_q <= timeoutCount_q + 32'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dmem_req      = dmemReq_q;
  assign dmem_we       = dmemWe_q;
  assign dmem_addr     = dmemAddr_q;
  assign dmem_wdata    = dmemWdata_q;
  assign dmem_be       = dmemBe_q;
  assign mem_read_data = memReadData_q;
  assign MEM_kick_up   = memKickUp_q;
  assign mem_fault     = memFault_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a behavioural bus responder.
module tb_mem_stage;

  localparam int TOUT = 4;

  logic        clk;
  logic        reset;
  logic        EX_kick_up;
  logic [31:0] ALU_result;
  logic [31:0] rs2_data;
  logic        Controller_memread;
  logic        Controller_memwrite;
  logic [2:0]  funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_read_data;
  logic        MEM_kick_up;
  logic        mem_fault;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
    logic [7:0]  latency;
    logic [7:0]  reqCycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } txnExp_t;

  txnExp_t     sbQ[$];
  int          compareCount;
  int          mismatchCount;
  logic [31:0] modelRead;

  mem_stage #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .EX_kick_up          (EX_kick_up),
    .ALU_result          (ALU_result),
    .rs2_data            (rs2_data),
    .Controller_memread  (Controller_memread),
    .Controller_memwrite (Controller_memwrite),
    .funct3              (funct3),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_be             (dmem_be),
    .dmem_ready          (dmem_ready),
    .dmem_rdata          (dmem_rdata),
    .mem_read_data       (mem_read_data),
    .MEM_kick_up         (MEM_kick_up),
    .mem_fault           (mem_fault)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Independent reference for load extraction.
  function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Drive one instruction, push its expectation, serve the bus and compare the result.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2,
                               input int waitCycles, input logic [31:0] rdata);
    txnExp_t e;
    txnExp_t got;
    logic    misaligned;
    logic    fault;
    int      cycles;
    int      reqCycles;
    misaligned = (f3[1:0] == 2'b01 && addr[0]) || (f3 == 3'b010 && addr[1:0] != 2'b00);
    fault = (rd && wr) ||
            (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
            (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) ||
            ((rd || wr) && misaligned);
    e = '0;
    e.addr = {addr[31:2], 2'b00};
    e.we   = wr;
    e.be   = 4'b1111;
    if (wr) begin
      case (f3)
        3'b000: begin
          case (addr[1:0])
            2'd0: e.be = 4'b0001;
            2'd1: e.be = 4'b0010;
            2'd2: e.be = 4'b0100;
            default: e.be = 4'b1000;
          endcase
          e.wdata = {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]};
        end
        3'b001: begin
          e.be    = addr[1] ? 4'b1100 : 4'b0011;
          e.wdata = {rs2[15:0], rs2[15:0]};
        end
        default: e.wdata = rs2;
      endcase
    end
    if (fault || (!rd && !wr)) begin
      e.fault = fault;
      e.latency = 8'd1;
      e.reqCycles = 8'd0;
    end else if (waitCycles < 0 || waitCycles >= TOUT) begin
      e.fault = 1'b1;
      e.latency = 8'(TOUT + 1);
      e.reqCycles = 8'(TOUT);
      modelRead = 32'h0;
    end else begin
      e.latency = 8'(waitCycles + 2);
      e.reqCycles = 8'(waitCycles + 1);
      if (rd) modelRead = loadModel(f3, addr[1:0], rdata);
    end
    e.data = modelRead;
    sbQ.push_back(e);

    @(negedge clk);
    EX_kick_up = 1'b1;
    Controller_memread = rd;
    Controller_memwrite = wr;
    funct3 = f3;
    ALU_result = addr;
    rs2_data = rs2;
    @(negedge clk);
    EX_kick_up = 1'b0;
    cycles = 1;
    reqCycles = 0;
    while (!MEM_kick_up && cycles < 20) begin
      if (dmem_req) begin
        reqCycles++;
        checkOutput("busAddr", dmem_addr, e.addr);
        checkOutput("busWeBe", {27'h0, dmem_we, dmem_be}, {27'h0, e.we, e.be});
        checkOutput("busWdata", dmem_wdata, e.wdata);
        if (reqCycles == waitCycles + 1) begin
          dmem_ready = 1'b1;
          dmem_rdata = rdata;
        end
      end
      @(negedge clk);
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      cycles++;
    end
    got = sbQ.pop_front();
    checkOutput("latency", cycles, {24'h0, got.latency});
    checkOutput("reqCycles", reqCycles, {24'h0, got.reqCycles});
    checkOutput("readData", mem_read_data, got.data);
    checkOutput("fault", {31'h0, mem_fault}, {31'h0, got.fault});
    @(negedge clk);
    checkOutput("kickPulse", {31'h0, MEM_kick_up}, 32'h0);
    checkOutput("reqIdle", {31'h0, dmem_req}, 32'h0);
  endtask

  initial begin
    compareCount = 0;
    mismatchCount = 0;
    modelRead = 32'h0;
    reset = 1'b0;
    EX_kick_up = 1'b0;
    ALU_result = '0;
    rs2_data = '0;
    Controller_memread = 1'b0;
    Controller_memwrite = 1'b0;
    funct3 = 3'b000;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstReq", {31'h0, dmem_req}, 32'h0);
    checkOutput("rstWe", {31'h0, dmem_we}, 32'h0);
    checkOutput("rstAddr", dmem_addr, 32'h0);
    checkOutput("rstWdata", dmem_wdata, 32'h0);
    checkOutput("rstBe", {28'h0, dmem_be}, 32'h0);
    checkOutput("rstRead", mem_read_data, 32'h0);
    checkOutput("rstKick", {31'h0, MEM_kick_up}, 32'h0);
    checkOutput("rstFault", {31'h0, mem_fault}, 32'h0);
    reset = 1'b1;

    // rd, wr, funct3, addr, rs2, waitCycles, rdata
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'hCAFE_F00D);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h5555_5555, 0, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h80FF_1234);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 2, 32'h0000_7F00);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 3, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 0, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0BAD_CAFE, 2, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h1111_1111);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 0, 32'h00C3_0000);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 0, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0, 0, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, -1, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, TOUT - 1, 32'h7654_3210);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom_range(0, 2), $urandom);
    end

    // Abandon a bus access with an asynchronous reset in the middle of it.
    @(negedge clk);
    EX_kick_up = 1'b1;
    Controller_memread = 1'b1;
    Controller_memwrite = 1'b0;
    funct3 = 3'b010;
    ALU_result = 32'h0000_0080;
    @(negedge clk);
    EX_kick_up = 1'b0;
    @(negedge clk);
    checkOutput("midBusReq", {31'h0, dmem_req}, 32'h1);
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncReqDrop", {31'h0, dmem_req}, 32'h0);
    checkOutput("asyncRead", mem_read_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    modelRead = 32'h0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0, 1, 32'hA5A5_0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the multi-cycle core. Sits between EX and WB: accepts the one-cycle `EX_kick_up` pulse with the ALU-computed address and store data, runs a request/ready transaction on the data-memory bus for loads and stores, aligns and extends load data, and emits the one-cycle `MEM_kick_up` pulse plus `mem_read_data` consumed by WB. Non-memory instructions pass through with fixed one-cycle latency.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles `dmem_req` may wait for `dmem_ready`; 0 disables timeout.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `EX_kick_up`  in  1  one-cycle pulse: EX outputs valid, start MEM.
- `ALU_result`  in  32  effective byte address.
- `rs2_data`  in  32  store data.
- `Controller_memread`  in  1  instruction is a load.
- `Controller_memwrite`  in  1  instruction is a store.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `dmem_req`  out  1  bus request, held until accepted.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address (`ALU_result[31:2]`,2'b00).
- `dmem_wdata`  out  32  store data shifted into byte lanes.
- `dmem_be`  out  4  byte enables (writes); 4'b1111 on reads.
- `dmem_ready`  in  1  bus accept/complete; read data valid same cycle.
- `dmem_rdata`  in  32  raw word read data.
- `mem_read_data`  out  32  aligned, extended load result; registered, held until next completion.
- `MEM_kick_up`  out  1  one-cycle pulse: stage complete.
- `mem_fault`  out  1  registered; set with `MEM_kick_up` on misaligned/illegal access or timeout; cleared on next `EX_kick_up`.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE + `EX_kick_up`: latch address, store data, funct3, read/write flags.
  - Neither read nor write: -> DONE.
  - Fault (H/HU with addr[0]=1; W with addr[1:0]≠0; load funct3 011/110/111; store funct3 ≠ 000/001/010; read and write both set): no bus request, `mem_fault` <= 1, -> DONE.
  - Otherwise -> BUS.
- BUS: `dmem_req`=1 with stable addr/we/wdata/be. Transfer on edge where `dmem_req && dmem_ready`: loads register extracted data into `mem_read_data`; -> DONE. Timeout counter reaching `TIMEOUT_CYCLES` without ready: drop req, `mem_fault` <= 1, `mem_read_data` <= 0, -> DONE.
- DONE: `MEM_kick_up`=1 for exactly this cycle, -> IDLE.
- Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}; SW be=4'b1111, wdata=rs2.
- Load extract: byte lane = rdata>>(8*addr[1:0]); B/H sign-extend from bit 7/15, BU/HU zero-extend, W unchanged.
- Non-load completions (stores, pass-through, faults) leave `mem_read_data` unchanged except timeout (0).
- `EX_kick_up` outside IDLE is a protocol violation: ignored, no state change.

## Timing
- Reset (async, immediate): state IDLE, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_be`=0, `mem_read_data`=0, `MEM_kick_up`=0, `mem_fault`=0, timeout counter 0. Reset during BUS drops `dmem_req` immediately; transaction abandoned.
- Pass-through/fault: `EX_kick_up` at cycle T -> `MEM_kick_up` at T+1.
- Bus access: `dmem_req` high from T+1; ready at T+1+k (k≥0) -> `MEM_kick_up` and new `mem_read_data` at T+2+k. Minimum latency 2.
- `dmem_req` never deasserts before ready except on timeout or reset; at most one outstanding request.
- Timeout: counter counts BUS cycles from 1; fault at cycle `TIMEOUT_CYCLES` if ready never seen; ready on that same cycle wins (normal completion).
- `MEM_kick_up` never high two consecutive cycles.

## Test plan
- Pass-through: `EX_kick_up` with memread=memwrite=0 -> `MEM_kick_up` next cycle, `dmem_req` never high, `mem_read_data` unchanged.
- LB addr 0x103, rdata 0x80FF_1234, ready immediately -> `mem_read_data`=0xFFFF_FF80 two cycles after kick; LBU same -> 0x0000_0080; LHU addr 0x102 -> 0x0000_80FF.
- SH addr 0x202, rs2=0xDEAD_BEEF, ready after 3 wait cycles -> dmem_addr=0x200, be=4'b1100, wdata=0xBEEF_BEEF, we=1 held 4 cycles; `MEM_kick_up` 5 cycles after kick, `mem_fault`=0.
- LW addr 0x101 -> no request, `mem_fault`=1 and `MEM_kick_up` next cycle; next valid access clears `mem_fault`.
- TIMEOUT_CYCLES=4, ready held low -> req high 4 cycles then drops, `mem_fault`=1, `mem_read_data`=0, single `MEM_kick_up`.
- Reset asserted mid-BUS -> `dmem_req` falls without clock; after release, fresh LW addr 0x0 completes normally.
